// File: rtl/cnn_pkg.sv
// cnn_pkg: shared constants, pixel type and window-element offset helper for the CNN datapath
package cnn_pkg;
  localparam int INT_SIZE = 8;
  localparam int WIN_K = 5;
  localparam int IMG_W = 28;
  localparam int IMG_H = 28;
  typedef logic [INT_SIZE-1:0] pixel_t;
  function automatic int win_off(int r, int c, int k, int isz);
    return (r * k + c) * isz;
  endfunction
endpackage

// File: rtl/conv_line_buf.sv
// conv_line_buf: Depth-deep pixel delay line that advances only when en is high
module conv_line_buf
  import cnn_pkg::*;
#(
  parameter int W = INT_SIZE,
  parameter int Depth = IMG_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);
  logic [Depth*W-1:0] sr;
  assign dout = sr[Depth*W-1 -: W];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sr <= '0;
    else if (en) sr <= {sr[(Depth-1)*W-1:0], din};
endmodule

// File: rtl/conv_window_gen.sv
// conv_window_gen: streaming KxK window generator over raster-order pixels.
// Optional CONV_WIN_FRAME_CNT_EN adds a 16-bit wrapping frame_count output.
module conv_window_gen
  import cnn_pkg::*;
#(
  parameter int IntSize = INT_SIZE,
  parameter int K = WIN_K,
  parameter int ImgW = IMG_W,
  parameter int ImgH = IMG_H
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [IntSize-1:0]     in_pixel,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [K*K*IntSize-1:0] out_window,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   frame_done
`ifdef CONV_WIN_FRAME_CNT_EN
  ,
  output logic [15:0]            frame_count
`endif
);
  localparam int CW = $clog2(ImgW);
  localparam int RW = $clog2(ImgH);
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [K*K*IntSize-1:0] win, nxt;
  logic [IntSize-1:0] chain [K];
  logic accept, produce, last_q;
  assign in_ready = !out_valid || out_ready;
  assign accept = in_valid && in_ready;
  assign produce = accept && row >= RW'(K-1) && col >= CW'(K-1);
  assign frame_done = out_valid && out_ready && last_q;
  // chain[n] is the pixel n rows above the current one, same column
  assign chain[0] = in_pixel;
  for (genvar i = 0; i < K-1; i++) begin : g_lb
    conv_line_buf #(.W(IntSize), .Depth(ImgW)) u_lb (
      .clk(clk), .rst_n(rst_n), .en(accept), .din(chain[i]), .dout(chain[i+1])
    );
  end
  for (genvar i = 0; i < K; i++) begin : g_r
    for (genvar j = 0; j < K; j++) begin : g_c
      if (j == K-1) begin : g_new
        assign nxt[win_off(i, j, K, IntSize) +: IntSize] = chain[K-1-i];
      end else begin : g_sh
        assign nxt[win_off(i, j, K, IntSize) +: IntSize] = win[win_off(i, j+1, K, IntSize) +: IntSize];
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
      win <= '0;
      out_window <= '0;
      out_valid <= 1'b0;
      last_q <= 1'b0;
    end else begin
      if (accept) begin
        win <= nxt;
        col <= (col == CW'(ImgW-1)) ? '0 : col + 1'b1;
        if (col == CW'(ImgW-1)) row <= (row == RW'(ImgH-1)) ? '0 : row + 1'b1;
      end
      if (produce) begin
        out_window <= nxt;
        last_q <= (row == RW'(ImgH-1)) && (col == CW'(ImgW-1));
      end
      out_valid <= produce || (out_valid && !out_ready);
    end
  end
`ifdef CONV_WIN_FRAME_CNT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) frame_count <= '0;
    else if (frame_done) frame_count <= frame_count + 16'd1;
`endif
endmodule

// File: tb/tb_conv_window_gen.sv
// tb_conv_window_gen: directed bench for conv_window_gen with a window-register reference model
module tb_conv_window_gen;
  import cnn_pkg::*;
  typedef logic [199:0] win_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  pixel_t in_pixel = '0;
  logic in_valid = 1'b0;
  logic in_ready;
  win_t out_window;
  logic out_valid;
  logic out_ready = 1'b1;
  logic frame_done;
`ifdef CONV_WIN_FRAME_CNT_EN
  logic [15:0] frame_count;
`endif
  int n_tests = 0;
  int n_fail = 0;
  int pulses = 0;
  logic exp_valid = 1'b0;
  logic exp_last = 1'b0;
  win_t exp_win = '0;

  conv_window_gen dut (
    .clk(clk), .rst_n(rst_n), .in_pixel(in_pixel), .in_valid(in_valid), .in_ready(in_ready),
    .out_window(out_window), .out_valid(out_valid), .out_ready(out_ready), .frame_done(frame_done)
`ifdef CONV_WIN_FRAME_CNT_EN
    , .frame_count(frame_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input win_t got, input win_t exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic pixel_t pix(input int seed, input int idx);
    return 8'(idx) ^ 8'(seed);
  endfunction

  // window whose bottom-right element is pixel (r,c): element k sits at row r-4+k/5, col c-4+k%5
  function automatic win_t model_win(input int seed, input int r, input int c);
    win_t w;
    for (int k = 0; k < 25; k++) w[k*8 +: 8] = pix(seed, (r - 4 + k / 5) * 28 + c - 4 + k % 5);
    return w;
  endfunction

  // mode 0: out_ready high, no gaps; 1: random gaps and random out_ready; 2: 10-cycle stall at pixel 300
  task automatic run_frame(input int seed, input int mode, input int npix);
    int idx = 0, cyc = 0, nwin = 0, stall = 0, r, c;
    logic stalled = 1'b0, prod, acc;
    while ((idx < npix || (npix == 784 && exp_valid)) && cyc < 6000) begin
      if (mode == 2 && idx == 300 && !stalled) begin
        stall = 10;
        stalled = 1'b1;
      end
      out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : (stall == 0);
      if (stall > 0) stall--;
      in_valid = idx < npix && (mode != 1 || $urandom_range(0, 3) != 0);
      in_pixel = pix(seed, idx);
      #1;
      acc = in_valid && (!exp_valid || out_ready);
      check("in_ready", win_t'(in_ready), win_t'(!exp_valid || out_ready));
      check("out_valid", win_t'(out_valid), win_t'(exp_valid));
      check("frame_done", win_t'(frame_done), win_t'(exp_valid && out_ready && exp_last));
      if (exp_valid) check("window", out_window, exp_win);
      if (exp_valid && out_ready) begin
        if (nwin == 0) begin
          check("first_e0", win_t'(out_window[7:0]), win_t'(pix(seed, 0)));
          if (seed == 0) begin
            check("first_e5", win_t'(out_window[47:40]), win_t'(28));
            check("first_e24", win_t'(out_window[199:192]), win_t'(116));
            if (mode == 0) check("first_lat", win_t'(cyc), win_t'(117));
          end
        end
        if (exp_last && seed == 0) begin
          check("last_e24", win_t'(out_window[199:192]), win_t'(15));
          check("last_e0", win_t'(out_window[7:0]), win_t'(155));
        end
        pulses += int'(exp_last);
        nwin++;
      end
      prod = 1'b0;
      if (acc) begin
        r = idx / 28;
        c = idx % 28;
        prod = r >= 4 && c >= 4;
        if (prod) begin
          exp_win = model_win(seed, r, c);
          exp_last = idx == 783;
        end
        idx++;
      end
      exp_valid = prod || (exp_valid && !out_ready);
      @(negedge clk);
      cyc++;
    end
    check("no_timeout", win_t'(cyc < 6000), win_t'(1));
    if (npix == 784) check("win_count", win_t'(nwin), win_t'(576));
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", win_t'(out_valid), win_t'(0));
    check("rst_out_window", out_window, win_t'(0));
    check("rst_in_ready", win_t'(in_ready), win_t'(1));
    check("rst_frame_done", win_t'(frame_done), win_t'(0));
    exp_valid = 1'b0;
    exp_last = 1'b0;
    exp_win = '0;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    do_reset();
    run_frame(0, 0, 784);
    run_frame(0, 2, 784);
`ifdef CONV_WIN_FRAME_CNT_EN
    check("frame_count2", win_t'(frame_count), win_t'(2));
`endif
    run_frame(0, 1, 784);
    pulses = 0;
    run_frame(8'h5a, 0, 784);
    run_frame(8'hc3, 0, 784);
    check("b2b_pulses", win_t'(pulses), win_t'(2));
    run_frame(0, 1, 300);
    do_reset();
    run_frame(0, 0, 784);
`ifdef CONV_WIN_FRAME_CNT_EN
    force dut.frame_count = 16'hffff;
    @(negedge clk);
    release dut.frame_count;
    run_frame(0, 0, 784);
    check("frame_count_wrap", win_t'(frame_count), win_t'(0));
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
